// File: rtl/tower_ctrl_pkg.sv
// Shared types for the stacking-game engine: FSM states, color codes and the
// mapping from LFSR bits to a block color.
package tower_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOVER,
    ST_FALL,
    ST_LAND,
    ST_OVER
  } state_t;

  typedef logic [1:0] color_t;

  localparam color_t CLR_NONE  = 2'b00;
  localparam color_t CLR_GREEN = 2'b01;
  localparam color_t CLR_BLUE  = 2'b10;
  localparam color_t CLR_RED   = 2'b11;

  localparam int         NUM_SLOTS = 16;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // A playable block always has a color, so the empty code folds onto green.
  function automatic color_t lfsr_color(input logic [7:0] s);
    color_t c;
    c = s[1:0];
    return (c == CLR_NONE) ? CLR_GREEN : c;
  endfunction

endpackage

// File: rtl/tower_ctrl_if.sv
// Control inputs and renderer-facing geometry/color bus of the tower engine.
interface tower_ctrl_if;
  import tower_pkg::*;

  logic        tick;
  logic        btn_drop;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [31:0] colors;
  logic [9:0]  fall_x;
  logic [9:0]  fall_y;
  color_t      fall_clr;
  logic [4:0]  height;
  logic [1:0]  lives;
  logic        game_over;
  logic        win;

  modport master (
    output tick, btn_drop,
    input  pos_x, pos_y, colors, fall_x, fall_y, fall_clr,
           height, lives, game_over, win
  );

  modport slave (
    input  tick, btn_drop,
    output pos_x, pos_y, colors, fall_x, fall_y, fall_clr,
           height, lives, game_over, win
  );

endinterface

// File: rtl/tower_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepping every cycle.
module lfsr8
  import tower_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule

// File: rtl/tower_ctrl.sv
// Stacking-game state engine: crane sweep, drop/fall/land sequence, overlap
// judging and the 16-slot tower color array, advancing once per frame tick.
module tower_ctrl
  import tower_pkg::*;
#(
  parameter int STACK_X    = 270,
  parameter int STACK_Y    = 400,
  parameter int BLK_W      = 100,
  parameter int BLK_H      = 20,
  parameter int HOVER_Y    = 40,
  parameter int X_MIN      = 20,
  parameter int X_MAX      = 520,
  parameter int CRANE_STEP = 4,
  parameter int FALL_STEP  = 5,
  parameter int TOL        = 30,
  parameter int LIVES      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  tower_ctrl_if.slave  bus
);

  if (STACK_Y - (NUM_SLOTS - 1) * BLK_H <= HOVER_Y + BLK_H) begin : g_bad_geom
    $error("tower_ctrl: top tower slot reaches the hover row");
  end
  if (X_MIN > X_MAX) begin : g_bad_sweep
    $error("tower_ctrl: X_MIN must not exceed X_MAX");
  end
  if (X_MAX + BLK_W > 1023) begin : g_bad_width
    $error("tower_ctrl: crane sweep leaves the 10-bit coordinate range");
  end

  state_t      state;
  logic [7:0]  lfsr_q;
  logic        right;
  logic [31:0] colors;
  logic [4:0]  height;
  logic [1:0]  lives;
  logic [9:0]  fall_x;
  logic [9:0]  fall_y;
  color_t      fall_clr;
  logic        game_over;
  logic        win;

  logic [9:0]  land_y;
  logic [10:0] x_up;
  logic        x_hits_max;
  logic        x_hits_min;
  logic        y_reach;
  logic [9:0]  dx;
  logic        hit;
  logic        restart;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr_q)
  );

  assign land_y     = 10'(STACK_Y - int'(height) * BLK_H);
  assign x_up       = {1'b0, fall_x} + 11'(CRANE_STEP);
  assign x_hits_max = x_up > 11'(X_MAX);
  assign x_hits_min = {1'b0, fall_x} < 11'(X_MIN + CRANE_STEP);
  assign y_reach    = ({1'b0, fall_y} + 11'(FALL_STEP)) >= {1'b0, land_y};

  always_comb begin
    dx = '0;
    if (fall_x >= 10'(STACK_X)) begin
      dx = fall_x - 10'(STACK_X);
    end else begin
      dx = 10'(STACK_X) - fall_x;
    end
  end

  assign hit = dx <= 10'(TOL);

  // A new game from OVER reuses the reset values but leaves the LFSR running.
  assign restart = (state == ST_OVER) && bus.btn_drop;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state     <= ST_IDLE;
      colors    <= '0;
      height    <= '0;
      lives     <= 2'(LIVES);
      fall_x    <= 10'(X_MIN);
      fall_y    <= 10'(HOVER_Y);
      fall_clr  <= CLR_NONE;
      right     <= 1'b1;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.btn_drop) begin
            state    <= ST_HOVER;
            fall_clr <= lfsr_color(lfsr_q);
          end
        end

        ST_HOVER: begin
          if (bus.btn_drop) begin
            state <= ST_FALL;
          end else if (bus.tick) begin
            if (right) begin
              if (x_hits_max) begin
                fall_x <= 10'(X_MAX);
                right  <= 1'b0;
              end else begin
                fall_x <= x_up[9:0];
              end
            end else begin
              if (x_hits_min) begin
                fall_x <= 10'(X_MIN);
                right  <= 1'b1;
              end else begin
                fall_x <= fall_x - 10'(CRANE_STEP);
              end
            end
          end
        end

        ST_FALL: begin
          if (bus.tick) begin
            if (y_reach) begin
              fall_y <= land_y;
              state  <= ST_LAND;
            end else begin
              fall_y <= fall_y + 10'(FALL_STEP);
            end
          end
        end

        ST_LAND: begin
          if (hit) begin
            colors[{height[3:0], 1'b0} +: 2] <= fall_clr;
            height <= height + 5'd1;
          end else begin
            lives <= lives - 2'd1;
          end
          if (hit && (height == 5'(NUM_SLOTS - 1))) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            win       <= 1'b1;
            fall_clr  <= CLR_NONE;
          end else if (!hit && (lives == 2'd1)) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
            fall_clr  <= CLR_NONE;
          end else begin
            state    <= ST_HOVER;
            fall_y   <= 10'(HOVER_Y);
            fall_clr <= lfsr_color(lfsr_q);
          end
        end

        ST_OVER: begin
          fall_clr <= CLR_NONE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pos_x     = 10'(STACK_X);
  assign bus.pos_y     = 10'(STACK_Y);
  assign bus.colors    = colors;
  assign bus.height    = height;
  assign bus.lives     = lives;
  assign bus.fall_x    = fall_x;
  assign bus.fall_y    = fall_y;
  assign bus.fall_clr  = fall_clr;
  assign bus.game_over = game_over;
  assign bus.win       = win;

endmodule

// File: tb/tb_tower_ctrl.sv
// Scoreboard bench for tower_ctrl: stimulus queues expected bus values per cycle,
// a monitor compares them one time unit after the clock edge they belong to.
module tb_tower_ctrl;

  typedef enum int {S_X, S_Y, S_CLR, S_COL, S_H, S_LIV, S_GO, S_WIN, S_PX, S_PY} sel_t;

  typedef struct {
    int unsigned cyc;
    sel_t        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned cyc_cnt;
  int unsigned n_pass;
  int unsigned n_total;
  exp_t q[$];
  logic [7:0] lf;

  int          mx, my, mh, mlives;
  bit          mdir, mgo, mwin;
  logic [31:0] mcolors;
  logic [1:0]  mclr;

  tower_ctrl_if bus();

  tower_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    if (!rst_n) lf <= 8'hA5;
    else        lf <= {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
  end

  function automatic logic [1:0] clr_of(input logic [7:0] s);
    return (s[1:0] == 2'b00) ? 2'b01 : s[1:0];
  endfunction

  function automatic logic [31:0] actual(input sel_t s);
    case (s)
      S_X:     return 32'(bus.fall_x);
      S_Y:     return 32'(bus.fall_y);
      S_CLR:   return 32'(bus.fall_clr);
      S_COL:   return bus.colors;
      S_H:     return 32'(bus.height);
      S_LIV:   return 32'(bus.lives);
      S_GO:    return 32'(bus.game_over);
      S_WIN:   return 32'(bus.win);
      S_PX:    return 32'(bus.pos_x);
      default: return 32'(bus.pos_y);
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic [31:0] a;
    #1;
    while (q.size() != 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      a = actual(e.sel);
      n_total++;
      if (a === e.val) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0h, expected %0h", e.name, cyc_cnt, a, e.val);
    end
  end

  task automatic expect1(input sel_t s, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.sel  = s;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic expect_state(input string tag);
    expect1(S_COL, mcolors, {tag, "_colors"});
    expect1(S_H, 32'(mh), {tag, "_height"});
    expect1(S_LIV, 32'(mlives), {tag, "_lives"});
    expect1(S_X, 32'(mx), {tag, "_fall_x"});
    expect1(S_Y, 32'(my), {tag, "_fall_y"});
    expect1(S_CLR, 32'(mclr), {tag, "_fall_clr"});
    expect1(S_GO, 32'(mgo), {tag, "_game_over"});
    expect1(S_WIN, 32'(mwin), {tag, "_win"});
  endtask

  task automatic model_reset();
    mx = 20; mdir = 1'b1; my = 40; mh = 0; mlives = 3;
    mcolors = '0; mclr = 2'b00; mgo = 1'b0; mwin = 1'b0;
  endtask

  task automatic drive(input logic t, input logic b);
    bus.tick = t;
    bus.btn_drop = b;
    @(negedge clk);
    bus.tick = 1'b0;
    bus.btn_drop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic crane_tick();
    if (mdir) begin
      if (mx + 4 > 520) begin mx = 520; mdir = 1'b0; end
      else mx = mx + 4;
    end else begin
      if (mx - 4 < 20) begin mx = 20; mdir = 1'b1; end
      else mx = mx - 4;
    end
    expect1(S_X, 32'(mx), "crane_x");
    drive(1'b1, 1'b0);
    idle(7);
  endtask

  task automatic move_to(input int target);
    for (int i = 0; i < 300 && mx != target; i++) crane_tick();
  endtask

  // Drop from HOVER, fall tick by tick, then either settle or reset inside LAND.
  task automatic drop_and_land(input bit with_tick, input bit rst_in_land);
    int  land;
    bit  hit;
    expect1(S_X, 32'(mx), with_tick ? "coincide_x" : "drop_x");
    drive(with_tick, 1'b1);
    idle(7);
    land = 400 - mh * 20;
    while (my + 5 < land) begin
      my = my + 5;
      expect1(S_Y, 32'(my), "fall_y");
      drive(1'b1, 1'b0);
      idle(7);
    end
    my = land;
    expect1(S_Y, 32'(my), "land_y");
    drive(1'b1, 1'b0);
    if (rst_in_land) begin
      rst_n = 1'b0;
      model_reset();
      expect_state("land_rst");
      idle(1);
      rst_n = 1'b1;
      idle(6);
    end else begin
      hit = ((mx >= 270) ? (mx - 270) : (270 - mx)) <= 30;
      if (hit) begin
        mcolors[2 * mh +: 2] = mclr;
        mh = mh + 1;
      end else begin
        mlives = mlives - 1;
      end
      if (mh == 16 || mlives == 0) begin
        mgo = 1'b1;
        mwin = (mh == 16);
        mclr = 2'b00;
      end else begin
        my = 40;
        mclr = clr_of(lf);
      end
      expect_state(hit ? "hit" : "miss");
      idle(7);
    end
  endtask

  task automatic restart_game();
    model_reset();
    expect_state("restart");
    drive(1'b0, 1'b1);
    mclr = clr_of(lf);
    expect1(S_CLR, 32'(mclr), "start_clr");
    drive(1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.btn_drop = 1'b0;
    @(negedge clk);
    model_reset();
    expect_state("reset");
    expect1(S_PX, 32'd270, "pos_x");
    expect1(S_PY, 32'd400, "pos_y");
    idle(1);
    rst_n = 1'b1;

    // Seed A5 has low bits 01 -> green.
    mclr = 2'b01;
    expect1(S_CLR, 32'(mclr), "first_clr");
    drive(1'b0, 1'b1);

    for (int i = 0; i < 130; i++) crane_tick();
    move_to(272);

    drop_and_land(1'b0, 1'b0);
    drop_and_land(1'b0, 1'b0);
    move_to(240);
    drop_and_land(1'b0, 1'b0);
    move_to(236);
    drop_and_land(1'b0, 1'b0);
    for (int i = 0; i < 300 && !(mx == 400 && mdir); i++) crane_tick();
    drop_and_land(1'b0, 1'b0);
    drop_and_land(1'b0, 1'b0);

    restart_game();
    move_to(272);
    for (int i = 0; i < 16; i++) drop_and_land(1'b0, 1'b0);

    restart_game();
    move_to(272);
    drop_and_land(1'b1, 1'b1);

    idle(3);
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
      n_total += q.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
